rom_access_arbiter: RTL
=======================

Name: rom_access_arbiter

Overview:
Shares the single synchronous-read instruction ROM between the instruction-fetch stage (IF) and the load unit (LS, for constant/table reads from ROM space). It accepts at most one request per cycle and drives the ROM address combinationally from the winning request. It routes the ROM data, registered inside the ROM, back to the owning requester one cycle later. LS has fixed priority, and a starvation counter guarantees forward progress for IF.

Parameters:
ROM_BYTES, 1024, ROM size in bytes; valid word addresses are 0..ROM_BYTES-4.
MAX_WAIT, 4, consecutive cycles IF may be denied before it is forced to win; must be >=1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req_valid  in  1  IF read request
if_req_addr  in  32  IF byte address
if_req_ready  out  1  IF request accepted this cycle
if_resp_valid  out  1  IF response pulse
if_resp_data  out  32  IF read data
if_resp_err  out  1  IF access was misaligned or out of range
ls_req_valid  in  1  LS read request
ls_req_addr  in  32  LS byte address
ls_req_ready  out  1  LS request accepted this cycle
ls_resp_valid  out  1  LS response pulse
ls_resp_data  out  32  LS read data
ls_resp_err  out  1  LS access was misaligned or out of range
rom_address  out  32  ROM address, sampled by the ROM on posedge clk
rom_data  in  32  ROM data, valid the cycle after the address is sampled

Behaviour:
- Reset (async): resp_owner=NONE, err_q=0, wait_cnt=0. All resp_valid/resp_err=0 and resp_data=0. rom_address=0 while no request is valid.
- Arbitration (combinational, per cycle):
  - If ls_req_valid and (wait_cnt!=MAX_WAIT or !if_req_valid): grant LS.
  - Else if if_req_valid: grant IF.
  - Else: no grant.
- Ready outputs: req_ready = grant for that port. There is no other back-pressure, so a lone valid request is accepted the same cycle.
- rom_address = granted address, else 32'h0. It is a pure mux, with no register, so the ROM samples it on the same edge that accepts the request.
- Acceptance edge: resp_owner <= granted port (NONE if no grant). err_q <= (addr[1:0]!=0) or (addr >= ROM_BYTES), evaluated on the granted address.
- Latency: exactly 1 cycle from acceptance to the response pulse.
  - In cycle N+1, owner_resp_valid=1 for one cycle.
  - owner_resp_data = err_q ? 0 : rom_data.
  - owner_resp_err = err_q.
  - The non-owner port sees valid=0, data=0 and err=0.
- Responses are unconditional; requesters must consume them. Back-to-back accepts give back-to-back responses (throughput 1 per cycle), and owners may alternate every cycle.
- Errored accesses still occupy one slot and still drive the ROM address (the ROM output is discarded).
- Starvation counter (width clog2(MAX_WAIT+1)):
  - Increments when if_req_valid and IF is not granted.
  - Clears when IF is granted or if_req_valid=0.
  - Saturates at MAX_WAIT; at MAX_WAIT IF wins the next contended cycle.
- Requesters must hold valid and addr stable until ready; the arbiter does not latch ungranted requests.
- Reset asserted mid-operation: any in-flight response is dropped (no pulse after reset deasserts), and the counter is cleared.
- Address bits above the ROM range are checked only for the range error; the ROM indexes with addr[9:2].

Test Plan:
- IF only, addr 0x8, ROM word 2 = 0xDEADBEEF -> cycle 0: if_req_ready=1, rom_address=0x8. Cycle 1: if_resp_valid=1, if_resp_data=0xDEADBEEF, err=0, ls_resp_valid=0.
- IF 0x4 and LS 0x10 both valid in one cycle -> ls_req_ready=1, if_req_ready=0, rom_address=0x10. Next cycle: IF granted (0x4), ls_resp_valid=1. Cycle after: if_resp_valid=1.
- Both valid continuously, MAX_WAIT=4 -> LS granted in cycles 0-3, IF granted in cycle 4, wait_cnt=0 afterwards, LS granted in cycle 5.
- LS addr 0x6 -> ls_resp_err=1, data=0. LS addr 0x400 (ROM_BYTES=1024) -> ls_resp_err=1, data=0. LS addr 0x3FC -> err=0, data = ROM word 255.
- IF accepted at 0x0, reset pulsed before the next edge -> no if_resp_valid, all outputs 0, wait_cnt=0. First request after reset is served normally with 1-cycle latency.
- Alternating IF/LS single requests for 8 cycles -> 8 responses, each tagged to the correct port, with data matching ROM contents.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read instruction ROM between instruction fetch (IF)
// and the load unit (LS). LS has fixed priority. A starvation counter forces
// an IF grant after MAX_WAIT consecutive denials. The ROM address is a pure
// combinational mux, and ROM data is routed to the owning port one cycle later.
module rom_access_arbiter #(
  parameter int ROM_BYTES = 1024,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  input  logic [31:0] ls_req_addr,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [31:0] ls_resp_data,
  output logic        ls_resp_err,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  owner_t          resp_owner;
  logic            err_q;
  logic [CW-1:0]   wait_cnt;

  logic            grant_ls;
  logic            grant_if;
  logic [31:0]     grant_addr;
  logic            grant_err;

  // LS wins unless IF has waited MAX_WAIT cycles and is still asking.
  always_comb begin
    grant_ls   = ls_req_valid && ((wait_cnt != WAIT_SAT) || !if_req_valid);
    grant_if   = if_req_valid && !grant_ls;
    grant_addr = 32'h0;
    if (grant_ls) begin
      grant_addr = ls_req_addr;
    end else if (grant_if) begin
      grant_addr = if_req_addr;
    end
    grant_err  = (grant_addr[1:0] != 2'b00) || (grant_addr >= 32'(ROM_BYTES));
  end

  assign ls_req_ready = grant_ls;
  assign if_req_ready = grant_if;
  assign rom_address  = grant_addr;

  // Record who owns the next ROM data word, its error flag, and IF's wait count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (grant_ls) begin
        resp_owner <= OWN_LS;
      end else if (grant_if) begin
        resp_owner <= OWN_IF;
      end else begin
        resp_owner <= OWN_NONE;
      end
      err_q <= grant_err;
      if (if_req_valid && !grant_if) begin
        if (wait_cnt != WAIT_SAT) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Steer the ROM output to the owner; errored slots return zero data.
  always_comb begin
    if_resp_valid = 1'b0;
    if_resp_data  = 32'h0;
    if_resp_err   = 1'b0;
    ls_resp_valid = 1'b0;
    ls_resp_data  = 32'h0;
    ls_resp_err   = 1'b0;
    case (resp_owner)
      OWN_IF: begin
        if_resp_valid = 1'b1;
        if_resp_data  = err_q ? 32'h0 : rom_data;
        if_resp_err   = err_q;
      end
      OWN_LS: begin
        ls_resp_valid = 1'b1;
        ls_resp_data  = err_q ? 32'h0 : rom_data;
        ls_resp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule
